// File: rtl/register_bank.sv
// Small arithmetic register bank: one operation per clock on bank[wr_addr],
// registered read-before-write port plus overflow and zero-result flags.
module register_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            ctrl,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] data_input,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic                  ovf,
  output logic                  zero
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  localparam logic [3:0] OP_CLR     = 4'd1;
  localparam logic [3:0] OP_LOAD    = 4'd2;
  localparam logic [3:0] OP_INCR    = 4'd3;
  localparam logic [3:0] OP_DECR    = 4'd4;
  localparam logic [3:0] OP_ADD     = 4'd5;
  localparam logic [3:0] OP_SUB     = 4'd6;
  localparam logic [3:0] OP_CLR_ALL = 4'd7;

  logic [DATA_WIDTH-1:0] bank_reg [NUM_REGS];

  logic [DATA_WIDTH-1:0] cur_val;
  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH:0]   sum_wide;
  logic [DATA_WIDTH:0]   diff_wide;
  logic [DATA_WIDTH-1:0] result_next;
  logic                  write_en;
  logic                  clr_all;
  logic                  active;
  logic                  ovf_next;
  logic [NUM_REGS-1:0]   sel;

  assign cur_val = bank_reg[wr_addr];

  // INCR/DECR reuse the ADD/SUB datapath with a constant operand of one.
  assign operand   = ((ctrl == OP_INCR) || (ctrl == OP_DECR)) ? DATA_WIDTH'(1) : data_input;
  assign sum_wide  = {1'b0, cur_val} + {1'b0, operand};
  assign diff_wide = {1'b0, cur_val} - {1'b0, operand};

  always_comb begin
    result_next = '0;
    write_en    = 1'b0;
    clr_all     = 1'b0;
    active      = 1'b1;
    ovf_next    = 1'b0;
    case (ctrl)
      OP_CLR: begin
        write_en    = 1'b1;
        result_next = '0;
      end
      OP_LOAD: begin
        write_en    = 1'b1;
        result_next = data_input;
      end
      OP_INCR, OP_ADD: begin
        write_en    = 1'b1;
        ovf_next    = sum_wide[DATA_WIDTH];
        result_next = (ovf_next && SATURATE) ? '1 : sum_wide[DATA_WIDTH-1:0];
      end
      OP_DECR, OP_SUB: begin
        write_en    = 1'b1;
        ovf_next    = diff_wide[DATA_WIDTH];
        result_next = (ovf_next && SATURATE) ? '0 : diff_wide[DATA_WIDTH-1:0];
      end
      OP_CLR_ALL: begin
        clr_all     = 1'b1;
        result_next = '0;
      end
      default: active = 1'b0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_sel
      assign sel[gi] = write_en && (wr_addr == ADDR_WIDTH'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) bank_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (clr_all)     bank_reg[i] <= '0;
        else if (sel[i]) bank_reg[i] <= result_next;
      end
    end
  end

  // Read samples the pre-write contents, so a same-address read lags one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_output <= '0;
      ovf         <= 1'b0;
      zero        <= 1'b0;
    end else begin
      data_output <= bank_reg[rd_addr];
      ovf         <= ovf_next;
      if (active) zero <= (result_next == '0);
    end
  end

endmodule
